// File: rtl/fifo_burst_arbiter.sv
// Round-robin arbiter with bounded burst locking. It registers the winning
// request word into a single output stage that feeds a FWFT FIFO input port.
module fifo_burst_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int MAX_BURST  = 4,
  parameter int SRC_WIDTH  = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            i__req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i__req_data,
  output logic [NUM_REQ-1:0]            o__req_ready,
  output logic                          o__data_out_valid,
  output logic [DATA_WIDTH-1:0]         o__data_out,
  output logic [SRC_WIDTH-1:0]          o__data_out_src,
  input  logic                          i__data_out_ready
);

  localparam int                   CNT_WIDTH = $clog2(MAX_BURST + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = CNT_WIDTH'(MAX_BURST);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [SRC_WIDTH-1:0] PTR_RST   = SRC_WIDTH'(NUM_REQ - 1);

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [SRC_WIDTH-1:0]  out_src_q, out_src_d;
  logic [SRC_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
  logic [SRC_WIDTH-1:0]  burst_owner_q, burst_owner_d;
  logic [CNT_WIDTH-1:0]  burst_cnt_q, burst_cnt_d;

  logic                  out_free;
  logic                  lock_hit;
  logic                  grant_valid;
  logic [SRC_WIDTH-1:0]  grant_idx;
  logic [DATA_WIDTH-1:0] req_data_arr [NUM_REQ];
  logic [SRC_WIDTH-1:0]  scan_idx     [NUM_REQ];
  logic [NUM_REQ-1:0]    scan_hit;

  assign out_free = !out_valid_q || i__data_out_ready;

  // scan_idx[gi] is the candidate at priority position gi. rr_ptr itself comes last.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign req_data_arr[gi] = i__req_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign scan_idx[gi]     = SRC_WIDTH'((int'(rr_ptr_q) + gi + 1) % NUM_REQ);
      assign scan_hit[gi]     = i__req_valid[scan_idx[gi]];
      assign o__req_ready[gi] = grant_valid && (grant_idx == SRC_WIDTH'(gi));
    end
  endgenerate

  assign lock_hit = (burst_cnt_q != '0) && (burst_cnt_q < CNT_MAX) &&
                    i__req_valid[burst_owner_q];

  // rr_ptr equals burst_owner whenever burst_cnt is non-zero. The scan after a
  // burst has ended therefore starts at owner+1.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    if (reset && out_free) begin
      if (lock_hit) begin
        grant_valid = 1'b1;
        grant_idx   = burst_owner_q;
      end else begin
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
          if (scan_hit[k]) begin
            grant_valid = 1'b1;
            grant_idx   = scan_idx[k];
          end
        end
      end
    end
  end

  always_comb begin
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_src_d     = out_src_q;
    rr_ptr_d      = rr_ptr_q;
    burst_owner_d = burst_owner_q;
    burst_cnt_d   = burst_cnt_q;
    if (grant_valid) begin
      out_valid_d = 1'b1;
      out_data_d  = req_data_arr[grant_idx];
      out_src_d   = grant_idx;
      rr_ptr_d    = grant_idx;
      // A re-grant to the owner after a full burst restarts the count at 1.
      if (lock_hit) begin
        burst_cnt_d = burst_cnt_q + CNT_ONE;
      end else begin
        burst_owner_d = grant_idx;
        burst_cnt_d   = CNT_ONE;
      end
    end else if (out_free) begin
      out_valid_d = 1'b0;
      if (!i__req_valid[burst_owner_q]) begin
        burst_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_src_q     <= '0;
      rr_ptr_q      <= PTR_RST;
      burst_owner_q <= '0;
      burst_cnt_q   <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_src_q     <= out_src_d;
      rr_ptr_q      <= rr_ptr_d;
      burst_owner_q <= burst_owner_d;
      burst_cnt_q   <= burst_cnt_d;
    end
  end

  assign o__data_out_valid = out_valid_q;
  assign o__data_out       = out_data_q;
  assign o__data_out_src   = out_src_q;

endmodule

// File: tb/tb_fifo_burst_arbiter.sv
// Directed bench for fifo_burst_arbiter. Expected words are queued when stimulus
// is set up and popped as the output stage hands words downstream.
module tb_fifo_burst_arbiter;
  localparam int NR = 4;
  localparam int DW = 64;
  localparam int SW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic             data_out_ready;

  logic [NR-1:0] ready_a, ready_b;
  logic          dv_a, dv_b;
  logic [DW-1:0] d_a, d_b;
  logic [SW-1:0] src_a, src_b;

  // Instance a uses bursts of up to 4 words. Instance b runs pure round-robin.
  fifo_burst_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset), .i__req_valid(req_valid), .i__req_data(req_data),
    .o__req_ready(ready_a), .o__data_out_valid(dv_a), .o__data_out(d_a),
    .o__data_out_src(src_a), .i__data_out_ready(data_out_ready));

  fifo_burst_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(1)) dut_rr (
    .clk(clk), .reset(reset), .i__req_valid(req_valid), .i__req_data(req_data),
    .o__req_ready(ready_b), .o__data_out_valid(dv_b), .o__data_out(d_b),
    .o__data_out_src(src_b), .i__data_out_ready(data_out_ready));

  logic          sel_rr = 1'b0;
  logic [NR-1:0] sel_ready;
  logic          sel_dv;
  logic [DW-1:0] sel_d;
  logic [SW-1:0] sel_src;
  assign sel_ready = sel_rr ? ready_b : ready_a;
  assign sel_dv    = sel_rr ? dv_b    : dv_a;
  assign sel_d     = sel_rr ? d_b     : d_a;
  assign sel_src   = sel_rr ? src_b   : src_a;

  int          checks = 0;
  int          errors = 0;
  int          remaining [NR];
  logic [63:0] seq       [NR];
  logic [63:0] exp_seq   [NR];
  logic [63:0] base      [NR];
  logic [SW-1:0] exp_src_q [$];
  logic [63:0]   exp_data_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int src);
    exp_src_q.push_back(SW'(src));
    exp_data_q.push_back(base[src] + exp_seq[src]);
    exp_seq[src]++;
  endtask

  task automatic drive_inputs();
    for (int k = 0; k < NR; k++) begin
      req_valid[k]         = remaining[k] > 0;
      req_data[k*DW +: DW] = base[k] + seq[k];
    end
  endtask

  // One clock: sample/score before the edge, advance the requesters after it.
  task automatic tick();
    logic [NR-1:0] acc;
    logic [63:0]   d;
    logic [SW-1:0] s;
    #1;
    acc = sel_ready & req_valid;
    if (sel_dv && data_out_ready) begin
      checks++;
      assert (exp_src_q.size() > 0) else begin
        errors++;
        $error("FAIL extra_word observed=src%0d/0x%0h expected=none", sel_src, sel_d);
      end
      if (exp_src_q.size() > 0) begin
        s = exp_src_q.pop_front();
        d = exp_data_q.pop_front();
        check("word_src", 64'(sel_src), 64'(s));
        check("word_data", sel_d, d);
      end
    end else if (sel_dv && exp_src_q.size() > 0) begin
      check("stall_ready", 64'(sel_ready), 64'h0);
      check("stall_data", sel_d, exp_data_q[0]);
      check("stall_src", 64'(sel_src), 64'(exp_src_q[0]));
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < NR; k++) begin
      if (acc[k]) begin
        seq[k]++;
        remaining[k]--;
      end
    end
    drive_inputs();
  endtask

  task automatic run_until_empty(input string tag, input int exp_cycles, input int max_cycles);
    int n = 0;
    while (exp_src_q.size() > 0 && n < max_cycles) begin
      tick();
      n++;
    end
    check({tag, "_cycles"}, 64'(n), 64'(exp_cycles));
    exp_src_q.delete();
    exp_data_q.delete();
    check({tag, "_drain"}, 64'(sel_dv), 64'h0);
  endtask

  task automatic apply_reset();
    reset          = 1'b0;
    data_out_ready = 1'b1;
    for (int k = 0; k < NR; k++) begin
      remaining[k] = 0;
      seq[k]       = '0;
      exp_seq[k]   = '0;
      base[k]      = 64'(k) << 32;
    end
    drive_inputs();
    exp_src_q.delete();
    exp_data_q.delete();
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state with every requester asserting valid.
    reset          = 1'b0;
    data_out_ready = 1'b1;
    for (int k = 0; k < NR; k++) begin
      remaining[k] = 1;
      seq[k]       = '0;
      base[k]      = '0;
    end
    drive_inputs();
    #2;
    check("rst_ready", 64'(ready_a), 64'h0);
    check("rst_valid", 64'(dv_a), 64'h0);
    check("rst_data", d_a, 64'h0);
    check("rst_src", 64'(src_a), 64'h0);

    // A single requester streams 10 words back to back.
    apply_reset();
    base[2]      = 64'hA0;
    remaining[2] = 10;
    for (int i = 0; i < 10; i++) push_exp(2);
    drive_inputs();
    run_until_empty("single", 11, 40);

    // All requesters valid: bursts of four, rotating, with no bubbles.
    apply_reset();
    for (int k = 0; k < NR; k++) remaining[k] = 8;
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < NR; k++)
        for (int i = 0; i < 4; i++) push_exp(k);
    drive_inputs();
    run_until_empty("all_valid", 33, 80);

    // Backpressure right after the first word. The burst then resumes intact.
    apply_reset();
    remaining[0] = 8;
    remaining[1] = 4;
    for (int i = 0; i < 4; i++) push_exp(0);
    for (int i = 0; i < 4; i++) push_exp(1);
    for (int i = 0; i < 4; i++) push_exp(0);
    drive_inputs();
    tick();
    data_out_ready = 1'b0;
    repeat (5) tick();
    data_out_ready = 1'b1;
    run_until_empty("backpressure", 12, 40);

    // The owner drops mid-burst. On reasserting, it waits out req 1's burst.
    apply_reset();
    remaining[0] = 2;
    remaining[1] = 6;
    push_exp(0); push_exp(0);
    for (int i = 0; i < 4; i++) push_exp(1);
    push_exp(0); push_exp(0);
    push_exp(1); push_exp(1);
    drive_inputs();
    repeat (4) tick();
    remaining[0] = 2;
    drive_inputs();
    run_until_empty("owner_drop", 7, 40);

    // Asynchronous reset while a word sits in the output stage.
    apply_reset();
    remaining[2] = 8;
    remaining[3] = 8;
    push_exp(2);
    drive_inputs();
    tick();
    tick();
    #1 reset = 1'b0;
    #1;
    check("midrst_valid", 64'(dv_a), 64'h0);
    check("midrst_ready", 64'(ready_a), 64'h0);
    apply_reset();
    remaining[2] = 4;
    remaining[3] = 4;
    for (int i = 0; i < 4; i++) push_exp(2);
    for (int i = 0; i < 4; i++) push_exp(3);
    drive_inputs();
    run_until_empty("after_reset", 9, 40);

    // Pure round-robin instance: requesters 1 and 3 alternate.
    sel_rr = 1'b1;
    apply_reset();
    remaining[1] = 4;
    remaining[3] = 4;
    for (int i = 0; i < 4; i++) begin
      push_exp(1);
      push_exp(3);
    end
    drive_inputs();
    run_until_empty("round_robin", 9, 40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
